// File: rtl/reg_seq_ctrl_pkg.sv
// Shared types for the register sequencer: operation and state encodings,
// default widths and shift-direction helpers.
package reg_seq_ctrl_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_CNT_WIDTH  = 4;

    typedef enum logic [2:0] {
        OP_SHL = 3'd0,
        OP_SHR = 3'd1,
        OP_ASR = 3'd2,
        OP_ROL = 3'd3,
        OP_ROR = 3'd4,
        OP_INC = 3'd5,
        OP_DEC = 3'd6,
        OP_CLR = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_STEP = 2'd2,
        S_DONE = 2'd3
    } state_t;

    function automatic logic is_left(input op_t o);
        return (o == OP_SHL) || (o == OP_ROL);
    endfunction

    function automatic logic is_right(input op_t o);
        return (o == OP_SHR) || (o == OP_ASR) || (o == OP_ROR);
    endfunction

endpackage

// File: rtl/reg_seq_ctrl_step_counter.sv
// Loadable down-counter for the step phase; last flags the final step.
module step_counter #(
    parameter int CNT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [CNT_WIDTH-1:0] load_val,
    input  logic                 dec,
    output logic                 last
);

    logic [CNT_WIDTH-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign last = (cnt == CNT_WIDTH'(1));

endmodule

// File: rtl/reg_seq_ctrl.sv
// Multi-cycle sequencer driving one register's control inputs for shift,
// rotate, step inc/dec and clear. Optional carry output: REG_SEQ_CTRL_CARRY_EN.
module reg_seq_ctrl
    import reg_seq_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [CNT_WIDTH-1:0]  count,
    input  logic [DATA_WIDTH-1:0] reg_q,
    output logic                  reg_cl,
    output logic                  reg_ld,
    output logic                  reg_inc,
    output logic                  reg_dec,
    output logic                  reg_sr,
    output logic                  reg_sl,
    output logic                  reg_ir,
    output logic                  reg_il,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            state_dbg
`ifdef REG_SEQ_CTRL_CARRY_EN
    ,
    output logic                  carry
`endif
);

    // Handshake: start is taken only on an IDLE edge (op/count latched there);
    // busy covers LOAD+STEP, done is a one-cycle pulse with the result on reg_q,
    // and start seen in any other state is dropped, never queued.
    state_t               state;
    op_t                  op_q;
    logic [CNT_WIDTH-1:0] count_q;
    logic                 cnt_last;
    logic                 step_next;

    step_counter #(.CNT_WIDTH(CNT_WIDTH)) u_step_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (state == S_LOAD),
        .load_val (count_q),
        .dec      (state == S_STEP),
        .last     (cnt_last)
    );

    assign step_next = ((state == S_LOAD) && (op_q != OP_CLR) && (count_q != '0)) ||
                       ((state == S_STEP) && !cnt_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            op_q    <= OP_SHL;
            count_q <= '0;
            reg_cl  <= 1'b0;
            reg_ld  <= 1'b0;
            reg_inc <= 1'b0;
            reg_dec <= 1'b0;
            reg_sr  <= 1'b0;
            reg_sl  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            reg_cl  <= 1'b0;
            reg_ld  <= 1'b0;
            reg_inc <= 1'b0;
            reg_dec <= 1'b0;
            reg_sr  <= 1'b0;
            reg_sl  <= 1'b0;
            done    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q    <= op_t'(op);
                        count_q <= count;
                        busy    <= 1'b1;
                        state   <= S_LOAD;
                        if (op_t'(op) == OP_CLR) reg_cl <= 1'b1;
                        else                     reg_ld <= 1'b1;
                    end
                end
                S_LOAD, S_STEP: begin
                    if (step_next) begin
                        state <= S_STEP;
                    end else begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
            // One step control per STEP cycle, chosen by the latched op.
            if (step_next) begin
                reg_sl  <= is_left(op_q);
                reg_sr  <= is_right(op_q);
                reg_inc <= (op_q == OP_INC);
                reg_dec <= (op_q == OP_DEC);
            end
        end
    end

    assign state_dbg = state;

    assign reg_il = reg_sl && (op_q == OP_ROL) && reg_q[DATA_WIDTH-1];
    assign reg_ir = reg_sr && (((op_q == OP_ASR) && reg_q[DATA_WIDTH-1]) ||
                               ((op_q == OP_ROR) && reg_q[0]));

`ifdef REG_SEQ_CTRL_CARRY_EN
    // Sampled before each step edge, so it sees the bit about to leave.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry <= 1'b0;
        end else if (state == S_LOAD) begin
            carry <= 1'b0;
        end else if (state == S_STEP) begin
            case (op_q)
                OP_SHL, OP_ROL:         carry <= reg_q[DATA_WIDTH-1];
                OP_SHR, OP_ASR, OP_ROR: carry <= reg_q[0];
                OP_INC:                 if (&reg_q) carry <= 1'b1;
                OP_DEC:                 if (reg_q == '0) carry <= 1'b1;
                default:                ;
            endcase
        end
    end
`else
    logic unused_reg_q;
    assign unused_reg_q = ^reg_q;
`endif

endmodule

// File: tb/tb_reg_seq_ctrl.sv
// Self-checking bench for reg_seq_ctrl with a behavioural register attached
// to its controls; carry checks appear when REG_SEQ_CTRL_CARRY_EN is defined.
module tb_reg_seq_ctrl;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [2:0]   op;
    logic [3:0]   count;
    logic [W-1:0] operand;
    logic [W-1:0] reg_q_m = '0;
    logic         reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_sl, reg_ir, reg_il;
    logic         busy, done;
    logic [1:0]   state_dbg;
`ifdef REG_SEQ_CTRL_CARRY_EN
    logic         carry;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] exp_q[$];
    logic         exp_c_q[$];
    int           exp_lat_q[$];

    int sl_cyc, sr_cyc, inc_cyc, dec_cyc, ir_cyc, il_cyc, busy_cyc, done_cnt, multi;

    reg_seq_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .count     (count),
        .reg_q     (reg_q_m),
        .reg_cl    (reg_cl),
        .reg_ld    (reg_ld),
        .reg_inc   (reg_inc),
        .reg_dec   (reg_dec),
        .reg_sr    (reg_sr),
        .reg_sl    (reg_sl),
        .reg_ir    (reg_ir),
        .reg_il    (reg_il),
        .busy      (busy),
        .done      (done),
        .state_dbg (state_dbg)
`ifdef REG_SEQ_CTRL_CARRY_EN
        ,
        .carry     (carry)
`endif
    );

    // Clock and the register under control (operand bus feeds its load input)
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reg_cl)       reg_q_m <= '0;
        else if (reg_ld)  reg_q_m <= operand;
        else if (reg_inc) reg_q_m <= reg_q_m + 1'b1;
        else if (reg_dec) reg_q_m <= reg_q_m - 1'b1;
        else if (reg_sr)  reg_q_m <= {reg_ir, reg_q_m[W-1:1]};
        else if (reg_sl)  reg_q_m <= {reg_q_m[W-2:0], reg_il};
    end

    always @(negedge clk) begin
        sl_cyc   <= sl_cyc + int'(reg_sl);
        sr_cyc   <= sr_cyc + int'(reg_sr);
        inc_cyc  <= inc_cyc + int'(reg_inc);
        dec_cyc  <= dec_cyc + int'(reg_dec);
        ir_cyc   <= ir_cyc + int'(reg_ir);
        il_cyc   <= il_cyc + int'(reg_il);
        busy_cyc <= busy_cyc + int'(busy);
        done_cnt <= done_cnt + int'(done);
        if ($countones({reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_sl}) > 1) multi <= multi + 1;
    end

    // Reference: step-by-step arithmetic, returns {carry, value}
    function automatic logic [W:0] ref_op(input logic [2:0] o, input int c, input logic [W-1:0] d);
        logic [W-1:0] v;
        logic cy;
        v = d;
        cy = 1'b0;
        if (o == 3'd7) return '0;
        for (int i = 0; i < c; i++) begin
            case (o)
                3'd0: begin cy = v[W-1]; v = {v[W-2:0], 1'b0}; end
                3'd1: begin cy = v[0]; v = {1'b0, v[W-1:1]}; end
                3'd2: begin cy = v[0]; v = {v[W-1], v[W-1:1]}; end
                3'd3: begin cy = v[W-1]; v = {v[W-2:0], v[W-1]}; end
                3'd4: begin cy = v[0]; v = {v[0], v[W-1:1]}; end
                3'd5: begin if (v == '1) cy = 1'b1; v = v + 1'b1; end
                default: begin if (v == '0) cy = 1'b1; v = v - 1'b1; end
            endcase
        end
        return {cy, v};
    endfunction

    task automatic clear_mon();
        sl_cyc = 0; sr_cyc = 0; inc_cyc = 0; dec_cyc = 0; ir_cyc = 0;
        il_cyc = 0; busy_cyc = 0; done_cnt = 0; multi = 0;
    endtask

    task automatic push_exp(input logic [2:0] o, input int c, input logic [W-1:0] d);
        logic [W:0] r;
        r = ref_op(o, c, d);
        exp_q.push_back(r[W-1:0]);
        exp_c_q.push_back(r[W]);
        exp_lat_q.push_back((o == 3'd7 || c == 0) ? 2 : c + 2);
    endtask

    // Drive one request; the accept edge is the posedge inside this task
    task automatic issue(input logic [2:0] o, input int c, input logic [W-1:0] d, input bit hold);
        @(negedge clk);
        op = o; count = c[3:0]; operand = d; start = 1'b1;
        push_exp(o, c, d);
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        clear_mon();
    endtask

    // Cycles counted from the accept edge; -1 when done never shows
    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!done && lat < 100);
        if (!done) lat = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; op = '0; count = '0; operand = '0;
        clear_mon();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_sl, reg_ir, reg_il, busy, done} !== 10'b0) begin
            n_fail++; $display("FAIL reset_outputs: got %b exp 0", {reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_sl, reg_ir, reg_il, busy, done});
        end
        n_checks++;
        if (state_dbg !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d exp 0", state_dbg); end
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_shift();
        int lat;
        logic [W-1:0] e;
        logic ec;
        // SHL 3 of 0x0001
        issue(3'd0, 3, 16'h0001, 1'b0);
        wait_done(lat);
        e = exp_q.pop_front(); ec = exp_c_q.pop_front();
        n_checks++; if (lat !== exp_lat_q.pop_front()) begin n_fail++; $display("FAIL shl_latency: got %0d exp 5", lat); end
        n_checks++; if (reg_q_m !== e) begin n_fail++; $display("FAIL shl_value: got %h exp %h", reg_q_m, e); end
`ifdef REG_SEQ_CTRL_CARRY_EN
        n_checks++; if (carry !== ec) begin n_fail++; $display("FAIL shl_carry: got %b exp %b", carry, ec); end
`endif
        @(posedge clk); #1;
        n_checks++; if (sl_cyc !== 3) begin n_fail++; $display("FAIL shl_sl_cycles: got %0d exp 3", sl_cyc); end
        n_checks++; if (busy_cyc !== 4) begin n_fail++; $display("FAIL shl_busy_cycles: got %0d exp 4", busy_cyc); end
        n_checks++; if (il_cyc !== 0) begin n_fail++; $display("FAIL shl_il_cycles: got %0d exp 0", il_cyc); end
        n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL shl_done_pulses: got %0d exp 1", done_cnt); end
        // ASR 4 of 0x8000: sign bit refilled on every step
        issue(3'd2, 4, 16'h8000, 1'b0);
        wait_done(lat);
        e = exp_q.pop_front(); ec = exp_c_q.pop_front();
        n_checks++; if (lat !== exp_lat_q.pop_front()) begin n_fail++; $display("FAIL asr_latency: got %0d exp 6", lat); end
        n_checks++; if (reg_q_m !== e) begin n_fail++; $display("FAIL asr_value: got %h exp %h", reg_q_m, e); end
        @(posedge clk); #1;
        n_checks++; if (ir_cyc !== 4) begin n_fail++; $display("FAIL asr_ir_cycles: got %0d exp 4", ir_cyc); end
        n_checks++; if (sr_cyc !== 4) begin n_fail++; $display("FAIL asr_sr_cycles: got %0d exp 4", sr_cyc); end
        // ROR 1 of 0x0001
        issue(3'd4, 1, 16'h0001, 1'b0);
        wait_done(lat);
        e = exp_q.pop_front(); ec = exp_c_q.pop_front();
        n_checks++; if (lat !== exp_lat_q.pop_front()) begin n_fail++; $display("FAIL ror_latency: got %0d exp 3", lat); end
        n_checks++; if (reg_q_m !== e) begin n_fail++; $display("FAIL ror_value: got %h exp %h", reg_q_m, e); end
`ifdef REG_SEQ_CTRL_CARRY_EN
        n_checks++; if (carry !== ec) begin n_fail++; $display("FAIL ror_carry: got %b exp %b", carry, ec); end
`endif
    endtask

    task automatic test_inc_dec();
        int lat;
        logic [W-1:0] e;
        logic ec;
        issue(3'd5, 15, 16'hFFF8, 1'b0);
        wait_done(lat);
        e = exp_q.pop_front(); ec = exp_c_q.pop_front();
        n_checks++; if (lat !== exp_lat_q.pop_front()) begin n_fail++; $display("FAIL inc_latency: got %0d exp 17", lat); end
        n_checks++; if (reg_q_m !== e) begin n_fail++; $display("FAIL inc_value: got %h exp %h", reg_q_m, e); end
`ifdef REG_SEQ_CTRL_CARRY_EN
        n_checks++; if (carry !== ec) begin n_fail++; $display("FAIL inc_carry: got %b exp %b", carry, ec); end
`endif
        @(posedge clk); #1;
        n_checks++; if (inc_cyc !== 15) begin n_fail++; $display("FAIL inc_cycles: got %0d exp 15", inc_cyc); end
        issue(3'd6, 2, 16'h0001, 1'b0);
        wait_done(lat);
        e = exp_q.pop_front(); ec = exp_c_q.pop_front();
        n_checks++; if (lat !== exp_lat_q.pop_front()) begin n_fail++; $display("FAIL dec_latency: got %0d exp 4", lat); end
        n_checks++; if (reg_q_m !== e) begin n_fail++; $display("FAIL dec_value: got %h exp %h", reg_q_m, e); end
`ifdef REG_SEQ_CTRL_CARRY_EN
        n_checks++; if (carry !== ec) begin n_fail++; $display("FAIL dec_carry: got %b exp %b", carry, ec); end
`endif
        @(posedge clk); #1;
        n_checks++; if (dec_cyc !== 2) begin n_fail++; $display("FAIL dec_cycles: got %0d exp 2", dec_cyc); end
    endtask

    task automatic test_clr_zero();
        int lat;
        logic [W-1:0] e;
        logic ec;
        issue(3'd7, 9, 16'hBEEF, 1'b0);
        wait_done(lat);
        e = exp_q.pop_front(); ec = exp_c_q.pop_front();
        n_checks++; if (lat !== exp_lat_q.pop_front()) begin n_fail++; $display("FAIL clr_latency: got %0d exp 2", lat); end
        n_checks++; if (reg_q_m !== e) begin n_fail++; $display("FAIL clr_value: got %h exp %h", reg_q_m, e); end
`ifdef REG_SEQ_CTRL_CARRY_EN
        n_checks++; if (carry !== ec) begin n_fail++; $display("FAIL clr_carry: got %b exp %b", carry, ec); end
`endif
        issue(3'd1, 0, 16'h1234, 1'b0);
        wait_done(lat);
        e = exp_q.pop_front(); ec = exp_c_q.pop_front();
        n_checks++; if (lat !== exp_lat_q.pop_front()) begin n_fail++; $display("FAIL shr0_latency: got %0d exp 2", lat); end
        n_checks++; if (reg_q_m !== e) begin n_fail++; $display("FAIL shr0_value: got %h exp %h", reg_q_m, e); end
        @(posedge clk); #1;
        n_checks++; if (sr_cyc !== 0) begin n_fail++; $display("FAIL shr0_sr_cycles: got %0d exp 0", sr_cyc); end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [W-1:0] e;
        logic ec;
        // start held high across the whole ROL, then a new op queued behind it
        issue(3'd3, 5, 16'h8001, 1'b1);
        wait_done(lat);
        e = exp_q.pop_front(); ec = exp_c_q.pop_front();
        n_checks++; if (lat !== exp_lat_q.pop_front()) begin n_fail++; $display("FAIL storm_latency: got %0d exp 7", lat); end
        n_checks++; if (reg_q_m !== e) begin n_fail++; $display("FAIL storm_value: got %h exp %h", reg_q_m, e); end
`ifdef REG_SEQ_CTRL_CARRY_EN
        n_checks++; if (carry !== ec) begin n_fail++; $display("FAIL storm_carry: got %b exp %b", carry, ec); end
`endif
        n_checks++; if (sl_cyc !== 5) begin n_fail++; $display("FAIL storm_sl_cycles: got %0d exp 5", sl_cyc); end
        op = 3'd0; count = 4'd2; operand = 16'h0003;
        push_exp(3'd0, 2, 16'h0003);
        @(negedge clk);
        n_checks++; if ({done, busy} !== 2'b00) begin n_fail++; $display("FAIL storm_idle_gap: got done,busy=%b exp 00", {done, busy}); end
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat);
        e = exp_q.pop_front(); ec = exp_c_q.pop_front();
        n_checks++; if (lat !== exp_lat_q.pop_front()) begin n_fail++; $display("FAIL b2b_latency: got %0d exp 4", lat); end
        n_checks++; if (reg_q_m !== e) begin n_fail++; $display("FAIL b2b_value: got %h exp %h", reg_q_m, e); end
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [W-1:0] e;
        logic ec;
        issue(3'd1, 8, 16'hFF00, 1'b0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_sl, reg_ir, reg_il} !== 8'b0) begin
            n_fail++; $display("FAIL midreset_controls: got %b exp 0", {reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_sl, reg_ir, reg_il});
        end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b exp 0", busy); end
        exp_q.delete(); exp_c_q.delete(); exp_lat_q.delete();
        clear_mon();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_checks++; if (done_cnt !== 0) begin n_fail++; $display("FAIL midreset_done: got %0d pulses exp 0", done_cnt); end
        issue(3'd0, 1, 16'h0001, 1'b0);
        wait_done(lat);
        e = exp_q.pop_front(); ec = exp_c_q.pop_front();
        n_checks++; if (lat !== exp_lat_q.pop_front()) begin n_fail++; $display("FAIL postreset_latency: got %0d exp 3", lat); end
        n_checks++; if (reg_q_m !== e) begin n_fail++; $display("FAIL postreset_value: got %h exp %h", reg_q_m, e); end
    endtask

    task automatic test_random();
        int lat, c;
        logic [2:0] o;
        logic [W-1:0] e;
        logic ec;
        for (int i = 0; i < 8; i++) begin
            o = 3'($urandom_range(0, 7));
            c = $urandom_range(0, 15);
            issue(o, c, 16'($urandom), 1'b0);
            wait_done(lat);
            e = exp_q.pop_front(); ec = exp_c_q.pop_front();
            n_checks++; if (lat !== exp_lat_q.pop_front()) begin n_fail++; $display("FAIL rand_latency[%0d]: op %0d cnt %0d got %0d", i, o, c, lat); end
            n_checks++; if (reg_q_m !== e) begin n_fail++; $display("FAIL rand_value[%0d]: op %0d cnt %0d got %h exp %h", i, o, c, reg_q_m, e); end
`ifdef REG_SEQ_CTRL_CARRY_EN
            n_checks++; if (carry !== ec) begin n_fail++; $display("FAIL rand_carry[%0d]: got %b exp %b", i, carry, ec); end
`endif
            @(posedge clk); #1;
            n_checks++; if (multi !== 0) begin n_fail++; $display("FAIL rand_onehot[%0d]: got %0d overlaps exp 0", i, multi); end
        end
    endtask

    initial begin
        test_reset();
        test_shift();
        test_inc_dec();
        test_clr_zero();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
